fifo_dp_ctrl: RTL and testbench
===============================

# fifo_dp_ctrl

Synchronous FIFO controller that turns an external dual-port RAM macro (active-low chip/write/output enables, one-cycle registered read latency) into a valid/ready streaming FIFO. Port A of the RAM is driven as the write port and port B as the read port. A 3-entry output buffer hides the RAM read latency, so the read side sustains one word per cycle with no combinational path from `rd_rdy_i` to the RAM. It sits between encoder pipeline stages that exchange data through on-chip line and coefficient buffers.

## Interface
- `DATA_W`, 32, word width; equals the RAM word width.
- `ADDR_W`, 8, RAM address width; RAM depth `DEPTH = 2**ADDR_W`.

- `clk`  in  1  single clock for the controller and both RAM ports.
- `rstn`  in  1  reset, asynchronous, active-low.
- `clr_i`  in  1  synchronous flush, active-high.
- `wr_val_i`  in  1  write data valid.
- `wr_dat_i`  in  DATA_W  write data.
- `wr_rdy_o`  out  1  space available (`ram_cnt != DEPTH`).
- `rd_val_o`  out  1  read data valid (registered).
- `rd_dat_o`  out  DATA_W  read data; head of the output buffer.
- `rd_rdy_i`  in  1  consumer accepts.
- `cnt_o`  out  ADDR_W+2  total words held (RAM + in flight + output buffer).
- `cena_o`, `wena_o`  out  1  RAM port A chip/write enable, low active.
- `oena_o`  out  1  tied 1; port A output is unused.
- `addra_o`  out  ADDR_W  write address.
- `dataa_o`  out  DATA_W  write data to the RAM.
- `cenb_o`  out  1  RAM port B chip enable, low active.
- `wenb_o`  out  1  tied 1; port B only reads.
- `oenb_o`  out  1  tied 0.
- `addrb_o`  out  ADDR_W  read address.
- `datab_o`  out  DATA_W  tied 0.
- `datab_i`  in  DATA_W  RAM port B read data, valid the cycle after `cenb_o` is low.

## Operation
- Push: `push = wr_val_i & wr_rdy_o`.
  - `cena_o = wena_o = ~push`, `addra_o = wptr`, `dataa_o = wr_dat_i`.
  - `wptr` increments, wrapping mod DEPTH.
- Issue: `issue = (ram_cnt != 0) & (ob_cnt + infl < 3)`.
  - `cenb_o = ~issue`, `addrb_o = rptr`.
  - `rptr` increments, wrapping; `infl <= issue`.
- Capture: when `infl` is 1, `datab_i` is written into the output buffer tail.
- Pop: `pop = rd_val_o & rd_rdy_i` removes the head.
  - `rd_val_o = (ob_cnt != 0)`.
  - Head and `rd_dat_o` are stable while `rd_val_o & ~rd_rdy_i`.
- Counter: `ram_cnt` takes +1 on push and −1 on issue; both in one cycle leaves it unchanged.
- No read/write collision: a word becomes readable only the cycle after its write, so the same address is never read and written in one cycle.
- Flow control:
  - A write while full is ignored and the RAM is not enabled.
  - `rd_rdy_i` with `rd_val_o` low is ignored.
- Occupancy: `cnt_o = ram_cnt + infl + ob_cnt`, maximum DEPTH+3.
- Flush: `clr_i` high zeroes pointers, counts, `infl` and the output buffer on the next edge.
  - Push, issue and pop are suppressed in that cycle.
  - A RAM word returning from an issue in the flush cycle is discarded.

## Timing
- Reset values:
  - `wr_rdy_o` = 1; `rd_val_o` = 0; `rd_dat_o` = 0; `cnt_o` = 0.
  - `cena_o`, `wena_o`, `cenb_o` = 1; addresses = 0.
- Latency, empty FIFO: push in cycle 0 → issue in cycle 1 → RAM data in cycle 2 → `rd_val_o` high in cycle 3.
- Throughput: sustained one word per cycle in and out.
- A stall of any length loses no data.
- `wr_rdy_o` is registered from `ram_cnt` and deasserts the cycle after the DEPTH-th word lands in the RAM.
- Reset mid-operation: all contents are lost and the RAM is left unenabled.

## Structure
- Shared package/header holds:
  - `OB_DEPTH = 3`.
  - RAM enable polarity constants (`RAM_EN = 1'b0`, `RAM_DIS = 1'b1`).
  - The DEPTH derivation.
- One sub-module, `fifo_ob3`: a 3-entry register FIFO with valid/ready output, count output, and sync clear.
- Pointers, counters and RAM port drive stay in the top.

## Test plan
- Reset, then a single write of 0xA5A5A5A5 in cycle 0 → `cenb_o` low in cycle 1; `rd_val_o` high with `rd_dat_o` = 0xA5A5A5A5 in cycle 3; `cnt_o` returns to 0 after the pop.
- Back-to-back stream of 1000 incrementing words with `rd_rdy_i` = 1 → data is in order, with no bubbles after the first output.
- With `ADDR_W` = 4, write 20 words with `rd_rdy_i` = 0:
  - `wr_rdy_o` drops once `cnt_o` = 19 (16 in RAM + 3 in the output buffer).
  - The 20th write is held off.
  - Draining yields words 0..19 exactly once, and the pointers wrap correctly.
- Random `wr_val_i`/`rd_rdy_i` at 50% over 10k cycles → scoreboard match, and the RAM port A/B addresses are never equal with both ports enabled in the same cycle.
- Assert `clr_i` with 7 words held and one read in flight → next cycle `cnt_o` = 0 and `rd_val_o` = 0; the next written word 0x1 is the first word read.
- Assert `rstn` low asynchronously mid-stream → outputs take their reset values immediately; normal operation resumes after release.

Source files
------------

// File: rtl/fifo_dp_ctrl_pkg.sv
// Shared constants for the dual-port RAM FIFO controller and its output buffer.
package fifo_dp_ctrl_pkg;
    localparam int   OB_DEPTH = 3;
    localparam logic RAM_EN   = 1'b0;
    localparam logic RAM_DIS  = 1'b1;

    function automatic int ram_depth(input int addr_w);
        return 1 << addr_w;
    endfunction
endpackage

// File: rtl/fifo_ob3.sv
// Three-entry register FIFO that absorbs the RAM read latency and presents
// a registered valid/ready stream to the consumer.
module fifo_ob3
    import fifo_dp_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_dat,
    output logic              rd_val,
    output logic [DATA_W-1:0] rd_dat,
    input  logic              rd_rdy,
    output logic [1:0]        cnt
);
    logic [DATA_W-1:0] mem [OB_DEPTH];
    logic [1:0]        head;
    logic [1:0]        tail;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_nxt;
    logic              val_q;
    logic              pop;

    function automatic logic [1:0] nxt_idx(input logic [1:0] idx);
        return (idx == 2'(OB_DEPTH - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

    assign pop = val_q & rd_rdy & ~clr;

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        cnt_nxt = cnt_q;
        if (wr_en && !pop) begin
            cnt_nxt = cnt_q + 2'd1;
        end else if (!wr_en && pop) begin
            cnt_nxt = cnt_q - 2'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            cnt_q <= '0;
            val_q <= 1'b0;
            // NOTE: only three words, so the array is reset to make rd_dat read zero out of reset; large RAM-like arrays are not.
            for (int i = 0; i < OB_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            head  <= '0;
            tail  <= '0;
            cnt_q <= '0;
            val_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[tail] <= wr_dat;
                tail      <= nxt_idx(tail);
            end
            if (pop) begin
                head <= nxt_idx(head);
            end
            cnt_q <= cnt_nxt;
            val_q <= (cnt_nxt != 2'd0);
        end
    end

    assign rd_val = val_q;
    assign rd_dat = mem[head];
    assign cnt    = cnt_q;
endmodule

// File: rtl/fifo_dp_ctrl.sv
// Valid/ready FIFO controller around an external dual-port RAM with
// active-low enables and one cycle of registered read latency.
module fifo_dp_ctrl
    import fifo_dp_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr_i,
    input  logic              wr_val_i,
    input  logic [DATA_W-1:0] wr_dat_i,
    output logic              wr_rdy_o,
    output logic              rd_val_o,
    output logic [DATA_W-1:0] rd_dat_o,
    input  logic              rd_rdy_i,
    output logic [ADDR_W+1:0] cnt_o,
    output logic              cena_o,
    output logic              wena_o,
    output logic              oena_o,
    output logic [ADDR_W-1:0] addra_o,
    output logic [DATA_W-1:0] dataa_o,
    output logic              cenb_o,
    output logic              wenb_o,
    output logic              oenb_o,
    output logic [ADDR_W-1:0] addrb_o,
    output logic [DATA_W-1:0] datab_o,
    input  logic [DATA_W-1:0] datab_i
);
    localparam int              DEPTH    = ram_depth(ADDR_W);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   ram_cnt;
    logic [ADDR_W:0]   ram_cnt_nxt;
    logic              full;
    logic              infl;
    logic              push;
    logic              issue;
    logic [1:0]        ob_cnt;

    // Gating with rstn keeps the RAM disabled during reset even if a writer holds wr_val_i.
    assign push  = rstn & ~clr_i & wr_val_i & ~full;
    assign issue = ~clr_i & (ram_cnt != '0) & ((int'(ob_cnt) + int'(infl)) < OB_DEPTH);

    always_comb begin
        ram_cnt_nxt = ram_cnt;
        if (push && !issue) begin
            ram_cnt_nxt = ram_cnt + (ADDR_W + 1)'(1);
        end else if (!push && issue) begin
            ram_cnt_nxt = ram_cnt - (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            full    <= 1'b0;
            infl    <= 1'b0;
        end else if (clr_i) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            full    <= 1'b0;
            infl    <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (issue) begin
                rptr <= rptr + ADDR_W'(1);
            end
            ram_cnt <= ram_cnt_nxt;
            full    <= (ram_cnt_nxt == FULL_CNT);
            infl    <= issue;
        end
    end

    // A word returning during a flush is dropped by the buffer's clear taking priority.
    fifo_ob3 #(
        .DATA_W (DATA_W)
    ) u_ob (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (clr_i),
        .wr_en  (infl),
        .wr_dat (datab_i),
        .rd_val (rd_val_o),
        .rd_dat (rd_dat_o),
        .rd_rdy (rd_rdy_i),
        .cnt    (ob_cnt)
    );

    assign wr_rdy_o = ~full;
    assign cnt_o    = {1'b0, ram_cnt} + (ADDR_W + 2)'(infl) + (ADDR_W + 2)'(ob_cnt);

    assign cena_o  = push ? RAM_EN : RAM_DIS;
    assign wena_o  = push ? RAM_EN : RAM_DIS;
    assign oena_o  = RAM_DIS;
    assign addra_o = wptr;
    assign dataa_o = wr_dat_i;

    assign cenb_o  = issue ? RAM_EN : RAM_DIS;
    assign wenb_o  = RAM_DIS;
    assign oenb_o  = RAM_EN;
    assign addrb_o = rptr;
    assign datab_o = '0;
endmodule

// File: tb/tb_fifo_dp_ctrl.sv
// Self-checking bench for fifo_dp_ctrl: RAM model, queue scoreboard checked every
// cycle, plus directed latency, fill, flush and async-reset scenarios.
module tb_fifo_dp_ctrl;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk      = 1'b0;
    logic              rstn     = 1'b0;
    logic              clr_i    = 1'b0;
    logic              wr_val_i = 1'b0;
    logic [DATA_W-1:0] wr_dat_i = '0;
    logic              rd_rdy_i = 1'b0;
    logic [DATA_W-1:0] datab_i  = '0;
    logic              wr_rdy_o;
    logic              rd_val_o;
    logic [DATA_W-1:0] rd_dat_o;
    logic [ADDR_W+1:0] cnt_o;
    logic              cena_o, wena_o, oena_o, cenb_o, wenb_o, oenb_o;
    logic [ADDR_W-1:0] addra_o, addrb_o;
    logic [DATA_W-1:0] dataa_o, datab_o;

    fifo_dp_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .clr_i    (clr_i),
        .wr_val_i (wr_val_i),
        .wr_dat_i (wr_dat_i),
        .wr_rdy_o (wr_rdy_o),
        .rd_val_o (rd_val_o),
        .rd_dat_o (rd_dat_o),
        .rd_rdy_i (rd_rdy_i),
        .cnt_o    (cnt_o),
        .cena_o   (cena_o),
        .wena_o   (wena_o),
        .oena_o   (oena_o),
        .addra_o  (addra_o),
        .dataa_o  (dataa_o),
        .cenb_o   (cenb_o),
        .wenb_o   (wenb_o),
        .oenb_o   (oenb_o),
        .addrb_o  (addrb_o),
        .datab_o  (datab_o),
        .datab_i  (datab_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM macro model: controls sampled mid-cycle, acted on at the next rising edge.
    logic [DATA_W-1:0] ram [DEPTH];
    logic              l_cena = 1'b1, l_wena = 1'b1, l_cenb = 1'b1;
    logic [ADDR_W-1:0] l_addra = '0, l_addrb = '0;
    logic [DATA_W-1:0] l_dataa = '0;

    always @(negedge clk) begin
        l_cena  <= cena_o;
        l_wena  <= wena_o;
        l_addra <= addra_o;
        l_dataa <= dataa_o;
        l_cenb  <= cenb_o;
        l_addrb <= addrb_o;
    end

    always @(posedge clk) begin
        if (rstn && !l_cena && !l_wena) ram[l_addra] <= l_dataa;
        if (rstn && !l_cenb) datab_i <= ram[l_addrb];
    end

    // Behavioural model: the FIFO content as a queue, plus write/read sequence numbers.
    logic [DATA_W-1:0] q [$];
    int                wcnt = 0, rcnt = 0, n_pop = 0, n_push = 0;
    logic [DATA_W-1:0] last_pop = '0;
    logic              prev_hold = 1'b0;
    logic              push_m, pop_m;

    always @(negedge clk) begin
        if (!rstn) begin
            check("rst_wr_rdy", wr_rdy_o, 1);
            check("rst_rd_val", rd_val_o, 0);
            check("rst_cnt", cnt_o, 0);
            check("rst_cena", cena_o, 1);
            check("rst_cenb", cenb_o, 1);
            check("rst_addra", addra_o, 0);
            check("rst_addrb", addrb_o, 0);
            q.delete();
            wcnt = 0;
            rcnt = 0;
            prev_hold = 1'b0;
        end else begin
            push_m = wr_val_i && wr_rdy_o && !clr_i;
            pop_m  = rd_val_o && rd_rdy_i && !clr_i;
            check("cnt", cnt_o, q.size());
            if (q.size() == 0) check("rd_val_empty", rd_val_o, 0);
            if (rd_val_o && q.size() > 0) check("rd_dat", rd_dat_o, q[0]);
            if (prev_hold) check("rd_val_hold", rd_val_o, 1);
            if (q.size() < DEPTH) check("wr_rdy_space", wr_rdy_o, 1);
            if (q.size() == DEPTH + 3) check("wr_rdy_full", wr_rdy_o, 0);
            check("cena", cena_o, !push_m);
            check("wena", wena_o, !push_m);
            if (push_m) begin
                check("addra", addra_o, wcnt % DEPTH);
                check("dataa", dataa_o, wr_dat_i);
            end
            if (!cenb_o) check("addrb", addrb_o, rcnt % DEPTH);
            if (!cena_o && !cenb_o) check("addr_collision", addra_o == addrb_o, 0);
            check("tied", {oena_o, wenb_o, oenb_o, (datab_o == '0)}, 4'b1101);
            if (clr_i) begin
                q.delete();
                wcnt = 0;
                rcnt = 0;
                prev_hold = 1'b0;
            end else begin
                if (pop_m && q.size() > 0) begin
                    last_pop = q.pop_front();
                    n_pop++;
                end
                if (push_m) begin
                    q.push_back(wr_dat_i);
                    wcnt++;
                    n_push++;
                end
                if (!cenb_o) rcnt++;
                prev_hold = rd_val_o && !rd_rdy_i;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds wr_val_i with d until accepted; leaves wr_val_i high for back-to-back use.
    task automatic push_word(input logic [DATA_W-1:0] d);
        bit done;
        done = 1'b0;
        wr_val_i = 1'b1;
        wr_dat_i = d;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            done = wr_rdy_o && !clr_i;
            step();
        end
        check("push_accept", done, 1);
    endtask

    task automatic wait_rd_val(input int budget, output bit ok, output logic [DATA_W-1:0] d);
        ok = 1'b0;
        d  = '0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            if (rd_val_o) begin
                ok = 1'b1;
                d  = rd_dat_o;
            end
            step();
        end
    endtask

    task automatic wait_empty(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            ok = (cnt_o == 0);
            step();
        end
        check(name, ok, 1);
    endtask

    int                base_pop, base_push, drop_cyc, w, bub;
    logic [ADDR_W+1:0] drop_cnt;
    bit                seen, ok;
    logic [DATA_W-1:0] d;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rstn = 1'b1;
        step();

        // Single word latency: push cycle 0, issue cycle 1, valid cycle 3.
        rd_rdy_i = 1'b1;
        wr_val_i = 1'b1;
        wr_dat_i = 32'hA5A5_A5A5;
        @(negedge clk); check("lat_c0_cena", cena_o, 0);
        step();
        wr_val_i = 1'b0;
        @(negedge clk); check("lat_c1_cenb", cenb_o, 0); check("lat_c1_cnt", cnt_o, 1);
        step();
        @(negedge clk); check("lat_c2_val", rd_val_o, 0);
        step();
        @(negedge clk); check("lat_c3_val", rd_val_o, 1); check("lat_c3_dat", rd_dat_o, 32'hA5A5_A5A5);
        step();
        @(negedge clk); check("lat_c4_cnt", cnt_o, 0);
        step();

        // Back-to-back stream of 1000 words; no bubbles after the first output.
        base_pop = n_pop;
        fork
            begin
                for (int i = 0; i < 1000; i++) push_word(i);
                wr_val_i = 1'b0;
            end
            begin
                seen = 1'b0;
                bub  = 0;
                for (int n = 0; n < 20 && !seen; n++) begin
                    @(negedge clk);
                    seen = rd_val_o;
                end
                check("stream_first", seen, 1);
                for (int i = 1; i < 1000; i++) begin
                    @(negedge clk);
                    if (!rd_val_o) bub++;
                end
                check("stream_bubbles", bub, 0);
            end
        join
        step();
        wait_empty("stream_drain", 50);
        check("stream_count", n_pop - base_pop, 1000);
        check("stream_last", last_pop, 999);

        // Fill with the consumer stalled: 16 in RAM + 3 in the buffer, 20th held off.
        rd_rdy_i = 1'b0;
        base_pop = n_pop;
        drop_cyc = -1;
        drop_cnt = '0;
        w = 0;
        wr_val_i = 1'b1;
        for (int cyc = 0; cyc < 60 && drop_cyc < 0; cyc++) begin
            wr_dat_i = w;
            @(negedge clk);
            if (wr_rdy_o) w++;
            else begin
                drop_cyc = cyc;
                drop_cnt = cnt_o;
            end
            step();
        end
        check("fill_drop_cycle", drop_cyc, 19);
        check("fill_drop_cnt", drop_cnt, 19);
        check("fill_accepted", w, 19);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fill_held_rdy", wr_rdy_o, 0);
            check("fill_held_cena", cena_o, 1);
            step();
        end
        rd_rdy_i = 1'b1;
        push_word(19);
        wr_val_i = 1'b0;
        wait_empty("fill_drain", 100);
        check("fill_count", n_pop - base_pop, 20);
        check("fill_last", last_pop, 19);

        // Random valid/ready at 50%.
        base_pop  = n_pop;
        base_push = n_push;
        for (int i = 0; i < 10000; i++) begin
            wr_val_i = 1'($urandom_range(0, 1));
            wr_dat_i = $urandom;
            rd_rdy_i = 1'($urandom_range(0, 1));
            step();
        end
        wr_val_i = 1'b0;
        rd_rdy_i = 1'b1;
        wait_empty("rand_drain", 100);
        check("rand_balance", n_pop - base_pop, n_push - base_push);

        // Flush with 7 words held and one RAM read in flight.
        rd_rdy_i = 1'b0;
        for (int i = 0; i < 8; i++) push_word(32'h100 + i);
        wr_val_i = 1'b0;
        repeat (6) step();
        rd_rdy_i = 1'b1;
        step();
        rd_rdy_i = 1'b0;
        step();
        clr_i = 1'b1;
        @(negedge clk); check("flush_pre_cnt", cnt_o, 7); check("flush_pre_val", rd_val_o, 1);
        step();
        clr_i = 1'b0;
        @(negedge clk); check("flush_post_cnt", cnt_o, 0); check("flush_post_val", rd_val_o, 0);
        step();
        rd_rdy_i = 1'b1;
        push_word(32'h1);
        wr_val_i = 1'b0;
        wait_rd_val(10, ok, d);
        check("flush_first_seen", ok, 1);
        check("flush_first_dat", d, 32'h1);
        wait_empty("flush_drain", 20);

        // Asynchronous reset mid-stream with a writer still asserting valid.
        for (int i = 0; i < 6; i++) push_word(32'h200 + i);
        wr_dat_i = 32'h206;
        #2 rstn = 1'b0;
        #1;
        check("arst_wr_rdy", wr_rdy_o, 1);
        check("arst_rd_val", rd_val_o, 0);
        check("arst_rd_dat", rd_dat_o, 0);
        check("arst_cnt", cnt_o, 0);
        check("arst_cena", cena_o, 1);
        check("arst_cenb", cenb_o, 1);
        check("arst_addra", addra_o, 0);
        check("arst_addrb", addrb_o, 0);
        wr_val_i = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b1;
        step();
        push_word(32'h77);
        wr_val_i = 1'b0;
        wait_rd_val(10, ok, d);
        check("arst_resume_seen", ok, 1);
        check("arst_resume_dat", d, 32'h77);
        wait_empty("arst_drain", 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
